// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one simple_bus master port between NUM_MASTERS requesters.
// Optional per-master grant counters and stall counter are enabled with `define BUS_ARB_STATS_EN.
module bus_master_arbiter #(
   parameter int XLEN        = 32,
   parameter int NUM_MASTERS = 2,
   parameter int DATA_W      = 64
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_MASTERS-1:0]        m_req_valid,
   input  logic [NUM_MASTERS*XLEN-1:0]   m_req_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_req_wdata,
   input  logic [NUM_MASTERS-1:0]        m_req_we,
   input  logic [NUM_MASTERS*3-1:0]      m_req_size,
   output logic [NUM_MASTERS-1:0]        m_req_ready,
   output logic [DATA_W-1:0]             m_req_rdata,
   output logic                          s_req_valid,
   output logic [XLEN-1:0]               s_req_addr,
   output logic [DATA_W-1:0]             s_req_wdata,
   output logic                          s_req_we,
   output logic [2:0]                    s_req_size,
   input  logic                          s_req_ready,
   input  logic [DATA_W-1:0]             s_req_rdata,
   output logic [NUM_MASTERS-1:0]        grant,
   output logic                          busy
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [NUM_MASTERS*32-1:0]     grant_count,
   output logic [31:0]                   stall_cycles
`endif
);

   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] owner_q, owner_d;
   logic [PW-1:0]          prio_q, prio_d;

   logic                   win_vld;
   logic [PW-1:0]          win_idx;
   logic [NUM_MASTERS-1:0] win_oh;
   logic [PW-1:0]          own_idx;
   logic [PW-1:0]          sel_idx;
   logic                   active;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(NUM_MASTERS - 1)) ? '0 : p + 1'b1;
   endfunction

   // Scan from the highest index offset down so the master closest to prio_q wins last.
   always_comb begin : arb_scan
      logic [PW-1:0] idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx = PW'((int'(prio_q) + k) % NUM_MASTERS);
         if (m_req_valid[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
      win_oh = '0;
      if (win_vld) win_oh[win_idx] = 1'b1;
   end

   always_comb begin : owner_enc
      own_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (owner_q[i]) own_idx = PW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : state_reg
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         prio_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               if (s_req_ready) begin
                  prio_d = next_ptr(win_idx);
               end else begin
                  owner_d = win_oh;
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            // An owner dropping valid aborts the transfer without moving priority.
            if (!m_req_valid[own_idx]) begin
               owner_d = '0;
               state_d = IDLE;
            end else if (s_req_ready) begin
               prio_d  = next_ptr(own_idx);
               owner_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            owner_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin : outputs
      active  = 1'b0;
      sel_idx = win_idx;
      grant   = '0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            active = win_vld;
            grant  = win_oh;
         end
         LOCKED: begin
            busy    = 1'b1;
            grant   = owner_q;
            sel_idx = own_idx;
            active  = m_req_valid[own_idx];
         end
         default: ;
      endcase

      s_req_valid = active;
      s_req_addr  = '0;
      s_req_wdata = '0;
      s_req_we    = 1'b0;
      s_req_size  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (active && (sel_idx == PW'(i))) begin
            s_req_addr  = m_req_addr[i*XLEN +: XLEN];
            s_req_wdata = m_req_wdata[i*DATA_W +: DATA_W];
            s_req_we    = m_req_we[i];
            s_req_size  = m_req_size[i*3 +: 3];
         end
      end

      // Completion is suppressed while reset is held so an interrupted transfer never reports done.
      m_req_ready = grant & {NUM_MASTERS{active & s_req_ready & reset_n}};
      m_req_rdata = s_req_rdata;
   end

`ifdef BUS_ARB_STATS_EN
   logic [31:0] grant_cnt_q [NUM_MASTERS];
   logic [31:0] stall_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin : stats_reg
      if (!reset_n) begin
         for (int i = 0; i < NUM_MASTERS; i++) grant_cnt_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (m_req_ready[i]) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
         end
         if (|(m_req_valid & ~grant)) stall_q <= sat_inc(stall_q);
      end
   end

   always_comb begin : stats_out
      for (int i = 0; i < NUM_MASTERS; i++) grant_count[i*32 +: 32] = grant_cnt_q[i];
      stall_cycles = stall_q;
   end
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (two masters, default widths).
module tb_bus_master_arbiter;

   localparam int XLEN = 32;
   localparam int NM   = 2;
   localparam int DW   = 64;

   logic              clk;
   logic              reset_n;
   logic [NM-1:0]     m_req_valid;
   logic [NM*XLEN-1:0] m_req_addr;
   logic [NM*DW-1:0]  m_req_wdata;
   logic [NM-1:0]     m_req_we;
   logic [NM*3-1:0]   m_req_size;
   logic [NM-1:0]     m_req_ready;
   logic [DW-1:0]     m_req_rdata;
   logic              s_req_valid;
   logic [XLEN-1:0]   s_req_addr;
   logic [DW-1:0]     s_req_wdata;
   logic              s_req_we;
   logic [2:0]        s_req_size;
   logic              s_req_ready;
   logic [DW-1:0]     s_req_rdata;
   logic [NM-1:0]     grant;
   logic              busy;
`ifdef BUS_ARB_STATS_EN
   logic [NM*32-1:0]  grant_count;
   logic [31:0]       stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   bus_master_arbiter #(.XLEN(XLEN), .NUM_MASTERS(NM), .DATA_W(DW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .m_req_valid (m_req_valid),
      .m_req_addr  (m_req_addr),
      .m_req_wdata (m_req_wdata),
      .m_req_we    (m_req_we),
      .m_req_size  (m_req_size),
      .m_req_ready (m_req_ready),
      .m_req_rdata (m_req_rdata),
      .s_req_valid (s_req_valid),
      .s_req_addr  (s_req_addr),
      .s_req_wdata (s_req_wdata),
      .s_req_we    (s_req_we),
      .s_req_size  (s_req_size),
      .s_req_ready (s_req_ready),
      .s_req_rdata (s_req_rdata),
      .grant       (grant),
      .busy        (busy)
`ifdef BUS_ARB_STATS_EN
      ,
      .grant_count (grant_count),
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int m, input logic v, input logic [31:0] a, input logic we,
                      input logic [2:0] sz, input logic [63:0] wd);
      m_req_valid[m]           = v;
      m_req_addr[m*XLEN +: XLEN] = a;
      m_req_we[m]              = we;
      m_req_size[m*3 +: 3]     = sz;
      m_req_wdata[m*DW +: DW]  = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n     = 1'b0;
      m_req_valid = '0;
      m_req_addr  = '0;
      m_req_wdata = '0;
      m_req_we    = '0;
      m_req_size  = '0;
      s_req_ready = 1'b0;
      s_req_rdata = 64'h1122_3344_5566_7788;
      #2;
      chk("rst_grant", grant, 0);
      chk("rst_valid", s_req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", m_req_ready, 0);
      chk("rst_addr", s_req_addr, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Single master, zero-wait read
      drv(0, 1'b1, 32'h8000_0000, 1'b0, 3'd2, 64'h0);
      s_req_ready = 1'b1;
      #1;
      chk("single_addr", s_req_addr, 32'h8000_0000);
      chk("single_ready", m_req_ready, 2'b01);
      chk("single_grant", grant, 2'b01);
      chk("single_rdata", m_req_rdata, 64'h1122_3344_5566_7788);
      chk("single_size", s_req_size, 3'd2);
      tick();

      // Tie with prio_ptr=1 goes to m1, whose write fields must be muxed through
      drv(0, 1'b1, 32'h0000_1000, 1'b0, 3'd2, 64'h0);
      drv(1, 1'b1, 32'h0000_2000, 1'b1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D);
      #1;
      chk("tie_ptr1_grant", grant, 2'b10);
      chk("tie_ptr1_addr", s_req_addr, 32'h0000_2000);
      chk("tie_ptr1_we", s_req_we, 1'b1);
      chk("tie_ptr1_wdata", s_req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("tie_ptr1_size", s_req_size, 3'd3);
      tick();

      // Both request continuously on a zero-wait bus: strict alternation
      for (int n = 0; n < 6; n++) begin
         #1;
         chk($sformatf("rr%0d_grant", n), grant, (n % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr%0d_ready", n), m_req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr%0d_addr", n), s_req_addr, (n % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
         tick();
      end

      // Wait states: m0 held for three LOCKED cycles while m1 keeps requesting
      s_req_ready = 1'b0;
      #1;
      chk("ws_idle_grant", grant, 2'b01);
      chk("ws_idle_busy", busy, 1'b0);
      tick();
      for (int n = 0; n < 3; n++) begin
         #1;
         chk($sformatf("ws%0d_grant", n), grant, 2'b01);
         chk($sformatf("ws%0d_busy", n), busy, 1'b1);
         chk($sformatf("ws%0d_ready", n), m_req_ready, 2'b00);
         tick();
      end
      s_req_ready = 1'b1;
      #1;
      chk("ws_done_ready", m_req_ready, 2'b01);
      chk("ws_done_busy", busy, 1'b1);
      tick();
      #1;
      chk("ws_next_grant", grant, 2'b10);
      chk("ws_next_busy", busy, 1'b0);
      chk("ws_next_ready", m_req_ready, 2'b10);
      tick();

      // Abort: m0 locks, then withdraws; priority must stay on m0
      s_req_ready = 1'b0;
      #1;
      chk("ab_idle_grant", grant, 2'b01);
      tick();
      drv(0, 1'b0, 32'h0000_1000, 1'b0, 3'd2, 64'h0);
      s_req_ready = 1'b1;
      #1;
      chk("ab_valid", s_req_valid, 1'b0);
      chk("ab_busy", busy, 1'b1);
      chk("ab_ready", m_req_ready, 2'b00);
      tick();
      drv(0, 1'b1, 32'h0000_1000, 1'b0, 3'd2, 64'h0);
      #1;
      chk("ab_after_busy", busy, 1'b0);
      chk("ab_after_grant", grant, 2'b01);
      tick();
      #1;
      chk("ab_m1_grant", grant, 2'b10);
      chk("ab_m1_ready", m_req_ready, 2'b10);
      tick();

      // Reset mid-LOCKED: move priority to m1, lock m1, then reset between edges
      drv(1, 1'b0, 32'h0000_2000, 1'b1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D);
      #1;
      chk("pre_rst_ready", m_req_ready, 2'b01);
      tick();
      drv(1, 1'b1, 32'h0000_2000, 1'b1, 3'd3, 64'hDEAD_BEEF_CAFE_F00D);
      s_req_ready = 1'b0;
      #1;
      chk("pre_rst_grant", grant, 2'b10);
      tick();
      #1;
      chk("locked_busy", busy, 1'b1);
      s_req_ready = 1'b1;
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_ready", m_req_ready, 2'b00);
      chk("arst_tie_grant", grant, 2'b01);
      m_req_valid = '0;
      #1;
      chk("arst_grant", grant, 2'b00);
      chk("arst_svalid", s_req_valid, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      m_req_valid = 2'b11;
      #1;
      chk("post_rst_grant", grant, 2'b01);
      chk("post_rst_ready", m_req_ready, 2'b01);
      tick();

`ifdef BUS_ARB_STATS_EN
      m_req_valid = '0;
      s_req_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("st_rst_stall", stall_cycles, 0);
      chk("st_rst_count", grant_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      m_req_valid = 2'b01;
      s_req_ready = 1'b1;
      tick();
      tick();
      tick();
      s_req_ready = 1'b0;
      tick();
      m_req_valid = 2'b11;
      tick();
      tick();
      s_req_ready = 1'b1;
      tick();
      m_req_valid = 2'b10;
      tick();
      tick();
      m_req_valid = 2'b00;
      s_req_ready = 1'b0;
      #1;
      chk("st_grant_count", grant_count, {32'd2, 32'd4});
      chk("st_stall", stall_cycles, 32'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Round-robin arbiter that shares the single simple_bus master port between NUM_MASTERS requesters, e.g. core data port, a DMA engine, or extra harts.
- Sits between the requesters and the bus master interface (valid/addr/wdata/we/size/ready/rdata).
- Forwards the winning request with zero added latency.
- Holds the grant until the bus completes the transfer.

Parameters:
XLEN, 32, address width
NUM_MASTERS, 2, number of requesters (legal range 2..8)
DATA_W, 64, wdata/rdata width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
m_req_valid  input  NUM_MASTERS  per-master request valid
m_req_addr  input  NUM_MASTERS*XLEN  per-master address, master i at [i*XLEN +: XLEN]
m_req_wdata  input  NUM_MASTERS*DATA_W  per-master write data
m_req_we  input  NUM_MASTERS  per-master write enable
m_req_size  input  NUM_MASTERS*3  per-master size code
m_req_ready  output  NUM_MASTERS  per-master completion, one-hot or zero
m_req_rdata  output  DATA_W  read data, broadcast to all masters
s_req_valid  output  1  request to bus
s_req_addr  output  XLEN  muxed address
s_req_wdata  output  DATA_W  muxed write data
s_req_we  output  1  muxed write enable
s_req_size  output  3  muxed size
s_req_ready  input  1  bus completion
s_req_rdata  input  DATA_W  bus read data
grant  output  NUM_MASTERS  one-hot current grant, zero when idle
busy  output  1  high while in LOCKED state

Behaviour:
- State machine: IDLE, LOCKED. Registers:
  - state
  - owner (one-hot)
  - prio_ptr (index of highest-priority master)
- Reset values: state=IDLE, owner=0, prio_ptr=0. Outputs are combinational from these registers and the inputs; with no requests, all outputs are 0.
- IDLE, combinational selection:
  - Winner = first asserted m_req_valid scanning prio_ptr, prio_ptr+1, ... modulo NUM_MASTERS.
  - grant = winner; the winner's request fields drive s_req_*; s_req_valid = 1.
- IDLE, completion: if s_req_ready=1 in the same cycle, m_req_ready[winner]=1, prio_ptr <= (winner+1) mod NUM_MASTERS, state stays IDLE.
- IDLE, stall: if s_req_ready=0, owner <= winner, state <= LOCKED.
- LOCKED:
  - grant = owner; owner's fields drive s_req_*; all other masters see ready=0 regardless of their valid.
  - On s_req_ready=1: m_req_ready[owner]=1, prio_ptr <= owner+1 (wrap), owner <= 0, state <= IDLE.
  - Next arbitration happens in the following cycle. The completion cycle is not re-used, so no back-to-back reuse within LOCKED.
- Abort: if the owner's m_req_valid drops while LOCKED, the transfer is aborted.
  - s_req_valid=0 that cycle; state <= IDLE, owner <= 0; prio_ptr unchanged.
- m_req_rdata = s_req_rdata at all times; a master may sample it only when its m_req_ready is high.
- Masters must hold request fields stable from valid until ready. The arbiter does not register request fields.
- Wrap-around: prio_ptr increments modulo NUM_MASTERS; pointer value NUM_MASTERS-1 wraps to 0.
- Simultaneous requests: the master with lowest (index - prio_ptr) mod NUM_MASTERS wins. A continuously requesting master cannot be starved beyond NUM_MASTERS-1 transfers.
- Asynchronous reset mid-transfer:
  - state, owner and prio_ptr are cleared immediately.
  - grant and s_req_valid fall as soon as no request is valid.
  - No m_req_ready is issued for the interrupted transfer.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- When defined, adds outputs:
  - grant_count (NUM_MASTERS*32): per master, incremented on each m_req_ready pulse, saturating at 0xFFFFFFFF.
  - stall_cycles (32): incremented each cycle in which any master has m_req_valid=1 but is not granted, saturating.
- Both counters reset to 0.
- When undefined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Single master: m0 read addr 0x8000_0000, s_req_ready same cycle -> s_req_addr=0x8000_0000, m_req_ready=2'b01 in that cycle, prio_ptr=1.
- Both request every cycle, zero-wait bus, 6 transfers -> grant sequence 01,10,01,10,01,10.
- Wait states: m0 granted, s_req_ready low 3 cycles, m1 valid throughout -> grant stays 01 and busy=1 for 3 cycles, m1 ready=0; m1 granted the cycle after m0 completes.
- Abort: m0 locked, m0 valid dropped -> s_req_valid=0 that cycle, state IDLE next cycle, prio_ptr still 0, m1 then granted.
- Reset mid-LOCKED: assert reset_n=0 asynchronously -> busy=0, grant=0 without waiting for clk, no m_req_ready pulse; after release, m0 wins a tie.
- BUS_ARB_STATS_EN: 4 transfers for m0, 2 for m1, with m1 blocked 3 cycles -> grant_count={2,4}, stall_cycles=3.
